// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and constants for the result UART transmitter.
//               tx_state_t     - frame FSM states
//               UART_DATA_BITS - payload bits per 8N1 frame
//               DEF_CLKS_PER_BIT - 100 MHz / 115200 baud
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int UART_DATA_BITS   = 8;
  localparam int DEF_CLKS_PER_BIT = 868;

endpackage
`default_nettype wire

// File: rtl/byte_fifo.sv
`default_nettype none
// ============================================================================
// Module      : byte_fifo
// Description : Synchronous FIFO with first-word-fall-through read data.
//               Pointers carry one extra wrap bit to tell full from empty.
// Ports       : clk   in            clock
//               rst_n in            asynchronous active-low reset
//               push  in            write din (accepted if not full, or if a
//                                   pop happens in the same cycle)
//               pop   in            discard head entry (ignored when empty)
//               din   in  [WIDTH]   write data
//               dout  out [WIDTH]   head entry, valid while !empty
//               full  out           DEPTH entries held
//               empty out           no entries held
// Revision    : 1.0 - initial release
// ============================================================================
module byte_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int c_AW = $clog2(DEPTH);

  logic [c_AW:0]      r_wr_ptr;
  logic [c_AW:0]      r_rd_ptr;
  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic               w_wr_en;
  logic               w_rd_en;

  assign empty   = (r_wr_ptr == r_rd_ptr);
  assign full    = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                   (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
  assign w_rd_en = pop && !empty;
  // A pop frees the head slot in the same edge, so a write while full is safe.
  assign w_wr_en = push && (!full || w_rd_en);
  assign dout    = r_mem[r_rd_ptr[c_AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: entries are only visible between the pointers.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr[c_AW-1:0]] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_result.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_result
// Description : Buffers result bytes from the glitch pipeline and sends them
//               to the host as 8N1 UART frames, timed from the system clock.
// Ports       : clk_in1  in       system clock
//               rst      in       asynchronous active-low reset
//               data_in  in  [8]  result byte
//               DV_in    in       one-cycle data-valid strobe
//               tx       out      serial line, idles high, registered
//               busy     out      frame in flight or bytes queued
//               overflow out      sticky: a byte was dropped on a full FIFO
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_result
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                      clk_in1,
  input  logic                      rst,
  input  logic [UART_DATA_BITS-1:0] data_in,
  input  logic                      DV_in,
  output logic                      tx,
  output logic                      busy,
  output logic                      overflow
);

  localparam int                    c_CW        = $clog2(CLKS_PER_BIT);
  localparam int                    c_IW        = $clog2(UART_DATA_BITS);
  localparam logic [c_CW-1:0]       c_BAUD_LAST = c_CW'(CLKS_PER_BIT - 1);
  localparam logic [c_IW-1:0]       c_IDX_LAST  = c_IW'(UART_DATA_BITS - 1);

  tx_state_t                 r_state;
  tx_state_t                 w_next_state;
  logic [c_CW-1:0]           r_baud;
  logic [c_IW-1:0]           r_idx;
  logic [UART_DATA_BITS-1:0] r_sh;
  logic [UART_DATA_BITS-1:0] w_sh_next;
  logic                      r_tx;
  logic                      w_tx_next;
  logic                      r_ovf;
  logic                      w_baud_last;
  logic                      w_pop;
  logic                      w_full;
  logic                      w_empty;
  logic [UART_DATA_BITS-1:0] w_dout;

  byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_fifo (
    .clk   (clk_in1),
    .rst_n (rst),
    .push  (DV_in),
    .pop   (w_pop),
    .din   (data_in),
    .dout  (w_dout),
    .full  (w_full),
    .empty (w_empty)
  );

  assign w_baud_last = (r_baud == c_BAUD_LAST);

  // ---- FSM: state register ------------------------------------------------
  always_ff @(posedge clk_in1 or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next_state;
  end

  // ---- FSM: next-state logic ----------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (!w_empty)                         w_next_state = START;
      START:   if (w_baud_last)                      w_next_state = DATA;
      DATA:    if (w_baud_last && r_idx == c_IDX_LAST) w_next_state = STOP;
      STOP:    if (w_baud_last)                      w_next_state = IDLE;
      default:                                       w_next_state = IDLE;
    endcase
  end

  // ---- FSM: outputs -------------------------------------------------------
  // tx is computed from the state being entered so that the registered line
  // lines up exactly with the state that owns it, with no output decode glitch.
  always_comb begin
    w_pop     = (r_state == IDLE) && !w_empty;
    w_sh_next = r_sh;
    if (w_pop)
      w_sh_next = w_dout;
    else if (r_state == DATA && w_baud_last)
      w_sh_next = r_sh >> 1;

    w_tx_next = 1'b1;
    case (w_next_state)
      START:   w_tx_next = 1'b0;
      DATA:    w_tx_next = w_sh_next[0];
      default: w_tx_next = 1'b1;
    endcase
  end

  // ---- Datapath: baud counter, bit index, shifter, line, overflow ---------
  always_ff @(posedge clk_in1 or negedge rst) begin
    if (!rst) begin
      r_baud <= '0;
      r_idx  <= '0;
      r_sh   <= '0;
      r_tx   <= 1'b1;
      r_ovf  <= 1'b0;
    end else begin
      // Counter restarts on every state entry and is parked in IDLE.
      if (w_next_state != r_state || r_state == IDLE || w_baud_last)
        r_baud <= '0;
      else
        r_baud <= r_baud + 1'b1;

      if (w_pop)
        r_idx <= '0;
      else if (r_state == DATA && w_baud_last)
        r_idx <= r_idx + 1'b1;

      r_sh <= w_sh_next;
      r_tx <= w_tx_next;

      // A pop in the same cycle makes room, so only a full FIFO without a pop drops.
      if (DV_in && w_full && !w_pop)
        r_ovf <= 1'b1;
    end
  end

  assign tx       = r_tx;
  assign overflow = r_ovf;
  assign busy     = (r_state != IDLE) || !w_empty;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_result.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_result
// Description : Self-checking bench for uart_tx_result (CLKS_PER_BIT=4,
//               FIFO_DEPTH=4). A frame-level reference model predicts which
//               bytes are accepted, when each frame starts and the line/busy/
//               overflow values; a UART receiver decodes tx and checks decoded
//               frames against the expected-frame queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_result;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk_in1 = 1'b0;
  logic       rst     = 1'b0;
  logic       DV_in   = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       tx;
  logic       busy;
  logic       overflow;

  uart_tx_result #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk_in1  (clk_in1),
    .rst      (rst),
    .data_in  (data_in),
    .DV_in    (DV_in),
    .tx       (tx),
    .busy     (busy),
    .overflow (overflow)
  );

  always #5 clk_in1 = ~clk_in1;

  int n_vec = 0;
  int n_err = 0;
  int unsigned ecnt = 0;   // number of rising edges seen

  // ---- reference model ----------------------------------------------------
  typedef struct {
    logic [7:0]  b;
    int unsigned st;
  } frame_t;

  logic [7:0]  mq[$];       // bytes waiting in the FIFO
  frame_t      sb[$];       // frames expected on the line
  bit          fr_act    = 1'b0;
  logic [7:0]  fr_byte   = 8'h00;
  int unsigned fr_start  = 0;  // edge after which tx goes low
  int unsigned next_pop  = 0;  // earliest edge the transmitter can take a byte
  bit          ovf_m     = 1'b0;
  bit          chk_en    = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, ecnt);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    sb.delete();
    fr_act   = 1'b0;
    next_pop = 0;
    ovf_m    = 1'b0;
  endtask

  // A frame is 10 bits of CPB cycles; the line then needs one idle cycle
  // before the next byte can be taken, giving a period of FRAME+1.
  task automatic model_edge();
    bit do_pop;
    bit room;
    do_pop = (mq.size() > 0) && (ecnt >= next_pop);
    room   = (mq.size() < DEPTH) || do_pop;
    if (do_pop) begin
      fr_byte  = mq.pop_front();
      fr_start = ecnt;
      fr_act   = 1'b1;
      next_pop = ecnt + FRAME + 1;
      sb.push_back('{b: fr_byte, st: ecnt});
    end
    if (DV_in) begin
      if (room) mq.push_back(data_in);
      else      ovf_m = 1'b1;
    end
  endtask

  function automatic bit in_frame();
    return fr_act && (ecnt - fr_start < FRAME);
  endfunction

  function automatic logic exp_tx();
    int unsigned k;
    if (!in_frame()) return 1'b1;
    k = (ecnt - fr_start) / CPB;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return fr_byte[k-1];
  endfunction

  always @(negedge rst) model_reset();

  always @(posedge clk_in1) begin
    ecnt++;
    if (rst) model_edge();
  end

  // ---- cycle checks ---------------------------------------------------------
  always @(negedge clk_in1) begin
    if (rst && chk_en) begin
      check("tx_line", tx, exp_tx());
      check("busy", busy, in_frame() || (mq.size() != 0));
      check("overflow", overflow, ovf_m);
    end
  end

  // ---- receiver / scoreboard monitor ---------------------------------------
  bit          rx_on = 1'b0;
  int          rx_n  = 0;
  int          rx_k  = 0;
  logic [7:0]  rx_b  = 8'h00;
  int unsigned rx_st = 0;
  frame_t      rx_e;

  always @(negedge clk_in1) begin
    if (!rst) begin
      rx_on = 1'b0;
    end else if (!rx_on) begin
      if (tx === 1'b0) begin
        rx_on = 1'b1;
        rx_n  = 0;
        rx_st = ecnt;
      end
    end else begin
      rx_n++;
      if (rx_n % CPB == CPB / 2) begin
        rx_k = rx_n / CPB;
        if (rx_k >= 1 && rx_k <= 8) begin
          rx_b[rx_k-1] = tx;
        end else if (rx_k == 9) begin
          check("stop_bit", tx, 1);
          if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL frame: got byte %02h, expected no frame", rx_b);
          end else begin
            rx_e = sb.pop_front();
            check("frame_byte", rx_b, rx_e.b);
            check("frame_start", rx_st, rx_e.st);
          end
          rx_on = 1'b0;
        end
      end
    end
  end

  // ---- stimulus -------------------------------------------------------------
  task automatic step(input bit dv, input logic [7:0] d);
    DV_in   = dv;
    data_in = d;
    @(posedge clk_in1);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'($urandom));
  endtask

  task automatic drain();
    int lim;
    lim = (DEPTH + 2) * (FRAME + 1) + 20;
    for (int i = 0; i < lim && busy !== 1'b0; i++) step(1'b0, 8'h00);
    check("drain_busy", busy, 0);
    idle(3);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    rst = 1'b1;
    step(1'b0, 8'h00);
  endtask

  task automatic burst(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) step(1'b1, first + 8'(i));
    step(1'b0, 8'h00);
  endtask

  initial begin
    #1;
    @(posedge clk_in1);
    #1;
    // reset values while held in reset
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_overflow", overflow, 0);
    step(1'b0, 8'h00);
    rst    = 1'b1;
    chk_en = 1'b1;

    // idle line
    idle(1000);

    // single byte
    step(1'b1, 8'hA5);
    step(1'b0, 8'h00);
    drain();

    // burst that exactly fills the FIFO
    burst(8'h01, 5);
    drain();

    // full FIFO with a push in the cycle the transmitter pops
    burst(8'h20, 5);
    for (int i = 0; i < 2 * FRAME && ecnt + 1 != next_pop; i++) step(1'b0, 8'h00);
    step(1'b1, 8'h25);
    check("fpp_overflow", overflow, 0);
    step(1'b0, 8'h00);
    drain();

    // overflow: sixth byte dropped, flag sticks
    burst(8'h10, 6);
    check("ovf_set", overflow, 1);
    drain();
    check("ovf_sticky", overflow, 1);

    // reset in the middle of data bit 3 of 0x3C
    step(1'b1, 8'h3C);
    step(1'b0, 8'h00);
    for (int i = 0; i < 4 * FRAME && !(in_frame() && ecnt - fr_start == 4 * CPB + 1); i++)
      step(1'b0, 8'h00);
    check("mid_bit3", tx, 1);
    rst = 1'b0;
    #1;
    check("mid_rst_tx", tx, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_overflow", overflow, 0);
    @(posedge clk_in1);
    #1;
    step(1'b0, 8'h00);
    rst = 1'b1;
    idle(100);
    check("post_rst_busy", busy, 0);

    // randomized traffic at several densities
    for (int ph = 0; ph < 3; ph++) begin
      int pct;
      pct = (ph == 0) ? 2 : (ph == 1) ? 3 : 40;
      for (int i = 0; i < 1200; i++)
        step($urandom_range(0, 99) < pct, 8'($urandom));
      drain();
      do_reset();
    end

    check("frames_pending", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
